// File: rtl/shizhong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shizhong_pkg
// Purpose  : Shared types and constants for the HH:MM:SS clock controller.
// Revision : 1.0  initial release
// ============================================================================
package shizhong_pkg;

  // Set-mode sequence; key_mode steps through these in declaration order.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_t;

  // Field maxima as packed BCD {tens, units}, compared directly against counters.
  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  // Blank masks, bit0 = m_g ... bit5 = s_s.
  localparam logic [5:0] BLANK_NONE = 6'b000000;
  localparam logic [5:0] BLANK_H    = 6'b000011;
  localparam logic [5:0] BLANK_M    = 6'b001100;
  localparam logic [5:0] BLANK_S    = 6'b110000;

  // Next state for a key_mode pulse: RUN->SET_H->SET_M->SET_S->RUN.
  function automatic state_t next_mode(input state_t s);
    case (s)
      ST_RUN:   return ST_SET_H;
      ST_SET_H: return ST_SET_M;
      ST_SET_M: return ST_SET_S;
      default:  return ST_RUN;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2_cnt.sv
`default_nettype none
// ============================================================================
// Module   : bcd2_cnt
// Purpose  : Two-digit BCD counter wrapping at a programmable maximum, with
//            synchronous clear and a carry strobe on wrap.
// Revision : 1.0  initial release
// ============================================================================
module bcd2_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_clr,
  input  logic [7:0] i_max,
  output logic [2:0] o_tens,
  output logic [3:0] o_units,
  output logic       o_carry_out
);

  logic [2:0] r_tens;
  logic [3:0] r_units;
  logic       w_at_max;

  assign w_at_max    = ({1'b0, r_tens} == i_max[7:4]) && (r_units == i_max[3:0]);
  // Carry only fires on a real increment that wraps; clear never carries.
  assign o_carry_out = i_inc && !i_clr && w_at_max;
  assign o_tens      = r_tens;
  assign o_units     = r_units;

  // Digit registers: clear has priority, then increment with BCD/max wrap.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_tens  <= 3'd0;
      r_units <= 4'd0;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_tens  <= 3'd0;
        r_units <= 4'd0;
      end else if (r_units >= 4'd9) begin
        r_tens  <= r_tens + 3'd1;
        r_units <= 4'd0;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shizhong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shizhong_ctrl
// Purpose  : 24-hour HH:MM:SS clock with key-driven set mode and blinking
//            of the field being edited; drives a six-digit scan display.
// Revision : 1.0  initial release
// ============================================================================
module shizhong_ctrl
  import shizhong_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [3:0] m_g,
  output logic [2:0] m_s,
  output logic [3:0] f_g,
  output logic [2:0] f_s,
  output logic [3:0] s_g,
  output logic [2:0] s_s,
  output logic [5:0] blank,
  output logic       sec_pulse
);

  localparam int c_PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int c_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(TICK_DIV - 1);
  localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_DIV - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [c_PW-1:0] r_presc;
  logic [c_BW-1:0] r_blink_cnt;
  logic            r_phase;
  logic            w_run;
  logic            w_tick;
  logic            w_inc_eff;
  logic            w_sec_carry;
  logic            w_min_carry;
  logic            w_unused_hr_carry;

  assign w_run     = (r_state == ST_RUN);
  // Second boundary; suppressed while rst is held so no phantom strobe appears.
  assign w_tick    = w_run && (r_presc == c_PRESC_LAST) && !rst;
  // key_mode wins when both keys arrive together.
  assign w_inc_eff = key_inc && !key_mode;
  assign sec_pulse = w_tick;

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  // Next mode: one step per key_mode pulse.
  always_comb begin
    w_state_next = r_state;
    if (key_mode) w_state_next = next_mode(r_state);
  end

  // Prescaler: runs only in RUN, parked at 0 otherwise so RUN re-entry gets a full second.
  always_ff @(posedge clk) begin
    if (rst || !w_run || w_tick) r_presc <= '0;
    else                         r_presc <= r_presc + 1'b1;
  end

  // Blink timebase: restarts with phase 0 on every mode change.
  always_ff @(posedge clk) begin
    if (rst || key_mode) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == c_BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Blank mask: dark only for the field being edited during the lit-off phase.
  always_comb begin
    blank = BLANK_NONE;
    if (r_phase) begin
      case (r_state)
        ST_SET_H: blank = BLANK_H;
        ST_SET_M: blank = BLANK_M;
        ST_SET_S: blank = BLANK_S;
        default:  blank = BLANK_NONE;
      endcase
    end
  end

  // Seconds: advance on tick, cleared by key_inc in SET_S.
  bcd2_cnt u_sec (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_tick),
    .i_clr       ((r_state == ST_SET_S) && w_inc_eff),
    .i_max       (MINSEC_MAX),
    .o_tens      (s_s),
    .o_units     (s_g),
    .o_carry_out (w_sec_carry)
  );

  // Minutes: carry from seconds only in RUN; key_inc in SET_M never carries on.
  bcd2_cnt u_min (
    .clk         (clk),
    .rst         (rst),
    .i_inc       ((w_run && w_sec_carry) || ((r_state == ST_SET_M) && w_inc_eff)),
    .i_clr       (1'b0),
    .i_max       (MINSEC_MAX),
    .o_tens      (f_s),
    .o_units     (f_g),
    .o_carry_out (w_min_carry)
  );

  // Hours: 00..23; carry out of hours has no consumer (day rollover is silent).
  bcd2_cnt u_hr (
    .clk         (clk),
    .rst         (rst),
    .i_inc       ((w_run && w_min_carry) || ((r_state == ST_SET_H) && w_inc_eff)),
    .i_clr       (1'b0),
    .i_max       (HOUR_MAX),
    .o_tens      (m_s),
    .o_units     (m_g),
    .o_carry_out (w_unused_hr_carry)
  );

endmodule
`default_nettype wire

// File: tb/tb_shizhong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shizhong_ctrl
// Purpose  : Directed self-checking bench for shizhong_ctrl (TICK_DIV=10,
//            BLINK_DIV=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_shizhong_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int BLINK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic [3:0] m_g, f_g, s_g;
  logic [2:0] m_s, f_s, s_s;
  logic [5:0] blank;
  logic       sec_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int first_pulse = -1;

  always #5 clk = ~clk;

  shizhong_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .m_g       (m_g),
    .m_s       (m_s),
    .f_g       (f_g),
    .f_s       (f_s),
    .s_g       (s_g),
    .s_s       (s_s),
    .blank     (blank),
    .sec_pulse (sec_pulse)
  );

  // Time as readable hex HHMMSS.
  function automatic logic [31:0] disp();
    return {8'h00, 1'b0, m_s, m_g, 1'b0, f_s, f_g, 1'b0, s_s, s_g};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulses();
    pulses      = 0;
    first_pulse = -1;
  endtask

  // n edges, counting strobes; first_pulse is the edge index of the first one.
  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      if (sec_pulse === 1'b1) begin
        if (pulses == 0) first_pulse = i;
        pulses++;
      end
    end
  endtask

  task automatic press_mode();
    key_mode = 1'b1;
    run(1);
    key_mode = 1'b0;
  endtask

  task automatic press_inc(input int n);
    key_inc = 1'b1;
    run(n);
    key_inc = 1'b0;
  endtask

  initial begin
    int last;

    // Reset state
    step();
    step();
    chk("rst_time",  disp(), 32'h000000);
    chk("rst_blank", {26'd0, blank}, 32'h0);
    chk("rst_pulse", {31'd0, sec_pulse}, 32'h0);
    rst = 1'b0;

    // 100 idle cycles: strobes at edges 9,19,..,99, 10 apart; time 00:00:10
    clr_pulses();
    last = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (sec_pulse === 1'b1) begin
        pulses++;
        if (last < 0) chk("first_pulse", i, 9);
        else          chk("pulse_gap", i - last, 10);
        last = i;
      end
    end
    chk("pulse_count_100", pulses, 10);
    chk("time_000010", disp(), 32'h000010);
    chk("run_blank", {26'd0, blank}, 32'h0);

    // SET_H, 25 increments: 00 -> 01 with wrap, no strobes
    clr_pulses();
    press_mode();
    press_inc(1);
    chk("set_h_inc1", disp(), 32'h010010);
    press_inc(24);
    chk("set_h_inc25", disp(), 32'h010010);
    chk("set_h_no_pulse", pulses, 0);

    // key_mode + key_inc together in SET_H: mode wins, nothing increments
    key_mode = 1'b1;
    key_inc  = 1'b1;
    step();
    key_mode = 1'b0;
    key_inc  = 1'b0;
    chk("mode_wins_time", disp(), 32'h010010);
    chk("blink_m_0", {26'd0, blank}, 32'h0);
    for (int j = 1; j < 16; j++) begin
      step();
      chk("blink_m", {26'd0, blank}, ((j / 4) % 2 == 1) ? 32'h0C : 32'h00);
    end

    // Minute wrap in SET_M does not touch hours
    press_inc(59);
    chk("set_m_59", disp(), 32'h015910);
    press_inc(1);
    chk("set_m_wrap", disp(), 32'h010010);

    // SET_S: blink mask, then key_inc clears seconds
    press_mode();
    run(4);
    chk("blink_s", {26'd0, blank}, 32'h30);
    press_inc(1);
    chk("set_s_clear", disp(), 32'h010000);

    // Back to RUN: first increment in cycle 10 after the transition cycle,
    // i.e. strobe sampled 9 edges after the transition edge.
    key_mode = 1'b1;
    step();
    key_mode = 1'b0;
    clr_pulses();
    run(590);
    chk("rerun_first_pulse", first_pulse, 9);
    chk("rerun_pulses", pulses, 59);
    chk("time_010059", disp(), 32'h010059);

    // Preset 23:59:59 without clearing seconds
    press_mode();
    run(4);
    chk("blink_h", {26'd0, blank}, 32'h03);
    press_inc(22);
    press_mode();
    press_inc(59);
    chk("preset_235959", disp(), 32'h235959);
    press_mode();
    clr_pulses();
    press_mode();
    run(10);
    chk("rollover_time", disp(), 32'h000000);
    chk("rollover_pulses", pulses, 1);

    // Reach 12:34:56 in SET_M, then reset with both keys asserted
    run(560);
    chk("time_000056", disp(), 32'h000056);
    press_mode();
    press_inc(12);
    press_mode();
    press_inc(34);
    chk("preset_123456", disp(), 32'h123456);
    rst      = 1'b1;
    key_mode = 1'b1;
    key_inc  = 1'b1;
    step();
    rst      = 1'b0;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    chk("midset_rst_time",  disp(), 32'h000000);
    chk("midset_rst_blank", {26'd0, blank}, 32'h0);
    chk("midset_rst_pulse", {31'd0, sec_pulse}, 32'h0);
    clr_pulses();
    run(30);
    chk("post_rst_first_pulse", first_pulse, 9);
    chk("post_rst_pulses", pulses, 3);
    chk("time_000003", disp(), 32'h000003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
